// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package  : uart_pkg
// Purpose  : UART timing constants, arbiter state encoding and width helpers.
// Revision : 1.0
// ============================================================================
package uart_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // Ceiling log2, never below 1 so single-entry indices keep a real bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic int baud_cnt_max(input int clk_freq, input int uart_bps);
        return clk_freq / uart_bps;
    endfunction

    function automatic int frame_cycles(input int clk_freq, input int uart_bps,
                                        input int gap_bits);
        return (10 + gap_bits) * baud_cnt_max(clk_freq, uart_bps);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : uart_tx_arbiter_if
// Purpose   : Requester bus plus transmitter launch signals of the arbiter.
// Revision  : 1.0
// ============================================================================
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    localparam int IDW = clog2(NUM_REQ);

    logic                   enable;
    logic [NUM_REQ-1:0]     req_valid;
    logic [8*NUM_REQ-1:0]   req_data;
    logic [NUM_REQ-1:0]     req_ready;
    logic [7:0]             pi_data;
    logic                   pi_flag;
    logic                   busy;
    logic [IDW-1:0]         grant_id;

    modport master (
        output enable, req_valid, req_data,
        input  req_ready, pi_data, pi_flag, busy, grant_id
    );

    modport slave (
        input  enable, req_valid, req_data,
        output req_ready, pi_data, pi_flag, busy, grant_id
    );

endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin pick, searching upward from ptr+1.
// Revision : 1.0
// ============================================================================
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IDW = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDW-1:0]     idx_o,
    output logic               any_req_o
);

    int cand;

    // Farthest candidate first, so the nearest one after ptr overwrites it.
    always_comb begin
        grant_o   = '0;
        idx_o     = '0;
        any_req_o = 1'b0;
        cand      = 0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand = (int'(ptr_i) + off) % NUM_REQ;
            if (req_i[cand]) begin
                grant_o       = '0;
                grant_o[cand] = 1'b1;
                idx_o         = IDW'(cand);
                any_req_o     = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Shares one 8N1 UART transmitter among NUM_REQ byte requesters.
// Revision : 1.0
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int UART_BPS = 9600,
    parameter int CLK_FREQ = 50000000,
    parameter int GAP_BITS = 1
) (
    input  logic              system_clk,
    input  logic              system_rst,
    uart_tx_arbiter_if.slave  bus
);

    localparam int IDW          = clog2(NUM_REQ);
    localparam int FRAME_CYCLES = frame_cycles(CLK_FREQ, UART_BPS, GAP_BITS);
    localparam int CNT_W        = clog2(FRAME_CYCLES);
    localparam logic [CNT_W-1:0] FRAME_LOAD = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [IDW-1:0]   PTR_RESET  = IDW'(NUM_REQ - 1);

    logic [0:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0] ready_q, ready_d;
    logic [7:0]         data_q, data_d;
    logic               flag_q, flag_d;
    logic               busy_q, busy_d;
    logic [IDW-1:0]     gid_q, gid_d;

    logic [NUM_REQ-1:0] w_grant;
    logic [IDW-1:0]     w_idx;
    logic               w_any;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req_i     (bus.req_valid),
        .ptr_i     (ptr_q),
        .grant_o   (w_grant),
        .idx_o     (w_idx),
        .any_req_o (w_any)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        ready_d = '0;
        data_d  = data_q;
        flag_d  = 1'b0;
        busy_d  = busy_q;
        gid_d   = gid_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.enable && w_any) begin
                    data_d  = bus.req_data[8*int'(w_idx) +: 8];
                    ready_d = w_grant;
                    flag_d  = 1'b1;
                    gid_d   = w_idx;
                    ptr_d   = w_idx;
                    cnt_d   = FRAME_LOAD;
                    busy_d  = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // The transmitter has no busy output, so the frame is timed here.
                if (cnt_q == '0) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge system_clk) begin
        if (system_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ptr_q   <= PTR_RESET;
            ready_q <= '0;
            data_q  <= 8'h00;
            flag_q  <= 1'b0;
            busy_q  <= 1'b0;
            gid_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            ready_q <= ready_d;
            data_q  <= data_d;
            flag_q  <= flag_d;
            busy_q  <= busy_d;
            gid_q   <= gid_d;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.pi_data   = data_q;
    assign bus.pi_flag   = flag_q;
    assign bus.busy      = busy_q;
    assign bus.grant_id  = gid_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Self-checking bench for uart_tx_arbiter with a frame-level model.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int CLK_FREQ = 1000;
    localparam int UART_BPS = 100;
    localparam int GAP_BITS = 1;
    localparam int BAUD     = CLK_FREQ / UART_BPS;
    localparam int FRAME    = (10 + GAP_BITS) * BAUD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus();

    uart_tx_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .UART_BPS (UART_BPS),
        .CLK_FREQ (CLK_FREQ),
        .GAP_BITS (GAP_BITS)
    ) dut (
        .system_clk (clk),
        .system_rst (rst),
        .bus        (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Frame-level reference: remaining busy cycles and last winner.
    logic [NUM_REQ-1:0] exp_ready = '0;
    logic [7:0]         exp_data  = '0;
    logic               exp_flag  = 1'b0;
    logic               exp_busy  = 1'b0;
    logic [1:0]         exp_gid   = '0;
    int                 m_ptr     = NUM_REQ - 1;
    int                 m_left    = 0;

    function automatic void model_update(input logic r, input logic en,
                                         input logic [NUM_REQ-1:0] v,
                                         input logic [8*NUM_REQ-1:0] d);
        int w;
        w = -1;
        exp_ready = '0;
        exp_flag  = 1'b0;
        if (r) begin
            exp_data = '0; exp_busy = 1'b0; exp_gid = '0;
            m_ptr = NUM_REQ - 1; m_left = 0;
        end else if (m_left > 0) begin
            m_left   = m_left - 1;
            exp_busy = (m_left > 0);
        end else if (en && (v != '0)) begin
            for (int k = 1; k <= NUM_REQ; k++)
                if (w < 0 && v[(m_ptr + k) % NUM_REQ]) w = (m_ptr + k) % NUM_REQ;
            exp_ready[w] = 1'b1;
            exp_flag     = 1'b1;
            exp_data     = d[8*w +: 8];
            exp_gid      = 2'(w);
            m_ptr        = w;
            m_left       = FRAME;
            exp_busy     = 1'b1;
        end
    endfunction

    function automatic logic [15:0] obs_vec();
        return {bus.req_ready, bus.pi_data, bus.pi_flag, bus.busy, bus.grant_id};
    endfunction

    function automatic logic [15:0] exp_vec();
        return {exp_ready, exp_data, exp_flag, exp_busy, exp_gid};
    endfunction

    task automatic step();
        logic s_rst, s_en;
        logic [NUM_REQ-1:0] s_v;
        logic [8*NUM_REQ-1:0] s_d;
        s_rst = rst; s_en = bus.enable; s_v = bus.req_valid; s_d = bus.req_data;
        @(posedge clk);
        model_update(s_rst, s_en, s_v, s_d);
        cyc++;
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Behavioural 8N1 transmitter: 2-cycle start latency, samples pi_data live.
    int   tx_t = -1;
    int   tx_bit;
    logic tx_line;

    always @(posedge clk) begin
        if (rst)                                  tx_t <= -1;
        else if (bus.pi_flag)                     tx_t <= 0;
        else if (tx_t >= 0 && tx_t < 1 + 10*BAUD) tx_t <= tx_t + 1;
        else                                      tx_t <= -1;
    end

    always_comb begin
        tx_line = 1'b1;
        tx_bit  = 0;
        if (tx_t >= 2) begin
            tx_bit = (tx_t - 2) / BAUD;
            if (tx_bit == 0)      tx_line = 1'b0;
            else if (tx_bit <= 8) tx_line = bus.pi_data[tx_bit-1];
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        step();
        step();
        checks++;
        if (obs_vec() !== 16'h0000) begin
            errors++;
            $display("FAIL reset_state got=%h exp=0000", obs_vec());
        end
    endtask

    task automatic test_single();
        int n;
        bus.req_valid = 4'b0001;
        bus.req_data  = 32'h0000_00A5;
        bus.enable    = 1'b1;
        step();
        rst = 1'b0;
        step();
        checks++;
        if (bus.req_ready !== 4'b0001 || bus.pi_flag !== 1'b1 ||
            bus.pi_data !== 8'hA5 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL single_grant got ready=%b flag=%b data=%h busy=%b exp 0001/1/a5/1",
                     bus.req_ready, bus.pi_flag, bus.pi_data, bus.busy);
        end
        bus.req_valid = '0;
        n = 0;
        for (int i = 0; i < 200 && bus.busy === 1'b1; i++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL single_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
            n++;
            step();
        end
        checks++;
        if (n !== FRAME) begin
            errors++;
            $display("FAIL single_busy_len got=%0d exp=%0d", n, FRAME);
        end
        checks++;
        if (bus.pi_data !== 8'hA5) begin
            errors++;
            $display("FAIL single_hold got=%h exp=a5", bus.pi_data);
        end
    endtask

    task automatic test_all_continuous();
        int t[5];
        int g[5];
        logic [7:0] d[5];
        int nf;
        rst = 1'b1;
        step();
        bus.req_valid = 4'hF;
        bus.req_data  = 32'h1312_1110;
        rst = 1'b0;
        nf = 0;
        for (int i = 0; i < 700 && nf < 5; i++) begin
            step();
            if (bus.pi_flag === 1'b1) begin
                t[nf] = cyc; g[nf] = int'(bus.grant_id); d[nf] = bus.pi_data; nf++;
            end
        end
        checks++;
        if (nf !== 5) begin
            errors++;
            $display("FAIL all_count got=%0d exp=5", nf);
        end
        for (int k = 0; k < nf; k++) begin
            checks++;
            if (g[k] !== k % 4 || d[k] !== 8'(8'h10 + k % 4)) begin
                errors++;
                $display("FAIL all_order k=%0d got id=%0d data=%h exp id=%0d", k, g[k], d[k], k % 4);
            end
        end
        for (int k = 1; k < nf; k++) begin
            checks++;
            if (t[k] - t[k-1] !== FRAME + 1) begin
                errors++;
                $display("FAIL all_spacing k=%0d got=%0d exp=%0d", k, t[k] - t[k-1], FRAME + 1);
            end
        end
        bus.req_valid = '0;
    endtask

    task automatic test_arrival_hold();
        bit early;
        int n;
        reset_dut();
        bus.req_valid = 4'b0010;
        bus.req_data  = 32'h0042_2100;
        step();
        checks++;
        if (bus.req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL arrival_first got=%b exp=0010", bus.req_ready);
        end
        bus.req_valid = '0;
        repeat (30) step();
        bus.req_valid = 4'b0100;
        early = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 300) begin
            if (bus.req_ready !== 4'b0000) early = 1'b1;
            step();
            n++;
        end
        checks++;
        if (early || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL arrival_hold got early=%0d busy=%b exp early=0 busy=0", early, bus.busy);
        end
        step();
        checks++;
        if (bus.req_ready !== 4'b0100 || bus.pi_data !== 8'h42) begin
            errors++;
            $display("FAIL arrival_grant got ready=%b data=%h exp 0100/42", bus.req_ready, bus.pi_data);
        end
        bus.req_valid = '0;
    endtask

    task automatic test_enable();
        bit seen;
        int n;
        reset_dut();
        bus.enable    = 1'b0;
        bus.req_valid = 4'b1000;
        bus.req_data  = 32'h3C00_0000;
        seen = 1'b0;
        repeat (500) begin
            step();
            if (bus.pi_flag !== 1'b0 || bus.req_ready !== 4'b0000) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL enable_block got grant=1 exp grant=0");
        end
        bus.enable = 1'b1;
        step();
        checks++;
        if (bus.req_ready !== 4'b1000 || bus.pi_flag !== 1'b1 ||
            bus.pi_data !== 8'h3C || bus.grant_id !== 2'd3) begin
            errors++;
            $display("FAIL enable_grant got ready=%b flag=%b data=%h id=%0d exp 1000/1/3c/3",
                     bus.req_ready, bus.pi_flag, bus.pi_data, bus.grant_id);
        end
        // Dropping enable mid-frame must not shorten the frame.
        bus.req_valid = 4'b0001;
        bus.req_data  = 32'h0000_0099;
        bus.enable    = 1'b0;
        n = 0;
        for (int i = 0; i < 200 && bus.busy === 1'b1; i++) begin
            n++;
            step();
        end
        checks++;
        if (n !== FRAME) begin
            errors++;
            $display("FAIL enable_frame_len got=%0d exp=%0d", n, FRAME);
        end
        seen = 1'b0;
        repeat (50) begin
            step();
            if (bus.pi_flag !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL enable_idle got grant=1 exp grant=0");
        end
        bus.enable = 1'b1;
        step();
        checks++;
        if (bus.req_ready !== 4'b0001 || bus.pi_data !== 8'h99) begin
            errors++;
            $display("FAIL enable_regrant got ready=%b data=%h exp 0001/99", bus.req_ready, bus.pi_data);
        end
        bus.req_valid = '0;
    endtask

    task automatic test_reset_mid();
        reset_dut();
        bus.req_valid = 4'b0010;
        bus.req_data  = 32'h0000_7700;
        step();
        bus.req_valid = '0;
        repeat (40) step();
        checks++;
        if (bus.busy !== 1'b1 || bus.grant_id !== 2'd1) begin
            errors++;
            $display("FAIL midrst_pre got busy=%b id=%0d exp 1/1", bus.busy, bus.grant_id);
        end
        rst = 1'b1;
        bus.req_valid = 4'b1111;
        bus.req_data  = 32'hDDCC_BBAA;
        step();
        checks++;
        if (obs_vec() !== 16'h0000) begin
            errors++;
            $display("FAIL midrst_state got=%h exp=0000", obs_vec());
        end
        rst = 1'b0;
        step();
        checks++;
        if (bus.req_ready !== 4'b0001 || bus.grant_id !== 2'd0 || bus.pi_data !== 8'hAA) begin
            errors++;
            $display("FAIL midrst_next got ready=%b id=%0d data=%h exp 0001/0/aa",
                     bus.req_ready, bus.grant_id, bus.pi_data);
        end
        bus.req_valid = '0;
    endtask

    task automatic test_random();
        reset_dut();
        for (int i = 0; i < 4000; i++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (bus.req_valid[r] && exp_ready[r]) begin
                    if ($urandom_range(1, 0) == 0) bus.req_valid[r] = 1'b0;
                    else bus.req_data[8*r +: 8] = 8'($urandom);
                end else if (bus.req_valid[r]) begin
                    if ($urandom_range(299, 0) == 0) bus.req_valid[r] = 1'b0;
                end else if ($urandom_range(24, 0) == 0) begin
                    bus.req_valid[r] = 1'b1;
                    bus.req_data[8*r +: 8] = 8'($urandom);
                end
            end
            if ($urandom_range(199, 0) == 0) bus.enable = ~bus.enable;
            rst = ($urandom_range(999, 0) == 0);
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
        end
        rst = 1'b0;
        bus.enable = 1'b1;
        bus.req_valid = '0;
    endtask

    task automatic test_end_to_end();
        logic line_s[260];
        logic [7:0] b1, b2;
        int s, s2;
        reset_dut();
        bus.enable    = 1'b1;
        bus.req_valid = 4'b0011;
        bus.req_data  = 32'h0000_C355;
        for (int i = 0; i < 260; i++) begin
            step();
            if (bus.req_ready[0] === 1'b1) bus.req_valid[0] = 1'b0;
            if (bus.req_ready[1] === 1'b1) bus.req_valid[1] = 1'b0;
            line_s[i] = tx_line;
        end
        s = -1;
        for (int i = 0; i < 260; i++) if (s < 0 && line_s[i] === 1'b0) s = i;
        checks++;
        if (s < 0 || s > 40) begin
            errors++;
            $display("FAIL e2e_start got=%0d exp=0..40", s);
        end else begin
            for (int k = 0; k < 8; k++) b1[k] = line_s[s + 15 + 10*k];
            checks++;
            if (b1 !== 8'h55 || line_s[s + 95] !== 1'b1) begin
                errors++;
                $display("FAIL e2e_frame1 got byte=%h stop=%b exp 55/1", b1, line_s[s + 95]);
            end
            s2 = -1;
            for (int i = s + 90; i < 260; i++) if (s2 < 0 && line_s[i] === 1'b0) s2 = i;
            checks++;
            if (s2 < 0 || s2 - (s + 90) < BAUD || s2 > 160) begin
                errors++;
                $display("FAIL e2e_gap got start2=%0d high=%0d exp high>=%0d", s2, s2 - (s + 90), BAUD);
            end else begin
                for (int k = 0; k < 8; k++) b2[k] = line_s[s2 + 15 + 10*k];
                checks++;
                if (b2 !== 8'hC3 || line_s[s2 + 95] !== 1'b1) begin
                    errors++;
                    $display("FAIL e2e_frame2 got byte=%h stop=%b exp c3/1", b2, line_s[s2 + 95]);
                end
            end
        end
    endtask

    initial begin
        bus.enable    = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        test_reset();
        test_single();
        test_all_continuous();
        test_arrival_hold();
        test_enable();
        test_reset_mid();
        test_random();
        test_end_to_end();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
